bus_slave_responder: RTL and testbench
======================================

// Module: bus_slave_responder
// PURPOSE
//  System-bus slave endpoint with local RAM; the responder for command_processor-style initiators.
//  Decodes instruction and slave_select, then runs write or read bursts into/out of RAM.
//  Signals completion on tx_done (write) / rx_done (read) for the initiator's WAITFINISH states.
// PARAMETERS
//  SLAVE_LEN  2   width of slave_select
//  ADDR_LEN   12  width of address
//  DATA_LEN   8   width of data / rd_data
//  BURST_LEN  12  width of burst_num
//  SLAVE_ID   0   this slave's select code
//  MEM_AW     10  RAM address width; depth = 2**MEM_AW words of DATA_LEN
// PORTS
//  clk           in   1          single clock, all logic on posedge
//  reset         in   1          synchronous, active-high
//  address       in   ADDR_LEN   burst start address
//  data          in   DATA_LEN   write beat data
//  data_valid    in   1          write beat strobe
//  burst_num     in   BURST_LEN  beats in burst; 0 treated as 1
//  slave_select  in   SLAVE_LEN  target slave code
//  instruction   in   2          00/01 idle, 10 write, 11 read
//  rd_data       out  DATA_LEN   read beat data
//  rd_valid      out  1          read beat strobe
//  tx_done       out  1          1-cycle pulse: write burst complete
//  rx_done       out  1          1-cycle pulse: read burst complete
//  busy          out  1          high in any state except IDLE
//  err           out  1          1-cycle error pulse; constant 0 without macro
// BEHAVIOUR
//  - Reset: state IDLE; rd_data=0, rd_valid=0, tx_done=0, rx_done=0, busy=0, err=0. RAM not cleared.
//  - Reset mid-burst aborts immediately; partial writes stay in RAM; no done pulse.
//  - States: IDLE, WRITE, READ, DONE, RELEASE.
//  - IDLE: accept when instruction[1]=1 and slave_select==SLAVE_ID.
//    - On accept, latch ptr=address[MEM_AW-1:0], cnt=max(burst_num,1), op=instruction[0].
//    - Next state is READ if op=1, WRITE if op=0.
//    - instruction 00/01 or a mismatched select: stay IDLE with no effect.
//  - Command inputs are sampled only at accept; changes while busy are ignored (except data/data_valid).
//  - WRITE: each cycle with data_valid=1: mem[ptr]<=data, ptr++, cnt--.
//    - data_valid=0 stalls the burst, with no timeout.
//    - data_valid in the accept cycle is ignored; the first beat is the cycle after accept.
//    - Last beat accepted -> DONE.
//  - READ: each cycle: rd_data<=mem[ptr], rd_valid<=1, ptr++, cnt--. No backpressure.
//    - First rd_valid is 2 cycles after the accept edge; beats are back-to-back.
//    - After the last beat -> DONE; rd_valid=0 from the DONE cycle on, rd_data holds its last value.
//  - DONE (1 cycle): tx_done=1 if op=0, rx_done=1 if op=1.
//    - DONE always goes to RELEASE.
//  - RELEASE: wait until instruction[1]==0, then IDLE. This blocks re-accepting the command the initiator is still holding.
//  - ptr wraps modulo 2**MEM_AW. Without the macro, address bits above MEM_AW are ignored (aliasing).
//  - burst_num > 2**MEM_AW: beats wrap and overwrite / re-read earlier locations.
//  - cnt is BURST_LEN wide; the done condition is cnt==1 on a consumed beat.
// CONFIGURATION
//  SLAVE_ERR_EN defined:
//    - At accept, range-check the command (below). Error if either holds:
//      - address[ADDR_LEN-1:MEM_AW] != 0;
//      - address[MEM_AW-1:0] + max(burst_num,1) > 2**MEM_AW.
//    - On error: no RAM access, no rd_valid; DONE pulses the matching done AND err together, then RELEASE.
//    - Wrap-around is then unreachable.
//  SLAVE_ERR_EN undefined: no range check; err tied 0; wrap/alias rules above apply.
// TESTING
//  1 write 10, addr 0x005, burst 3, data A1,B2,C3 back-to-back -> tx_done 1 cycle after C3; RAM[5..7]=A1,B2,C3.
//  2 read 11, addr 0x005, burst 3 -> rd_valid 3 cycles, rd_data A1,B2,C3; rx_done pulse the cycle after.
//  3 slave_select != SLAVE_ID, or instruction 01 -> busy stays 0, no done, RAM unchanged.
//  4 Hold instruction=10 for 5 cycles after tx_done -> exactly one transaction; IDLE only after instruction=00.
//  5 Write addr 0x3FF, burst 2 (MEM_AW=10):
//    - no macro -> RAM[0x3FF], RAM[0x000] written;
//    - SLAVE_ERR_EN -> err+tx_done pulse, RAM untouched.
//  6 Assert reset during beat 2 of a 4-beat read -> next cycle outputs all 0, state IDLE, no rx_done.

Source files
------------

// File: rtl/bus_slave_responder.sv
// System-bus slave endpoint with local RAM: accepts write/read bursts and signals tx_done/rx_done.
// Optional SLAVE_ERR_EN macro adds an accept-time range check that rejects out-of-RAM bursts with err.
module bus_slave_responder #(
    parameter int SLAVE_LEN = 2,
    parameter int ADDR_LEN  = 12,
    parameter int DATA_LEN  = 8,
    parameter int BURST_LEN = 12,
    parameter int SLAVE_ID  = 0,
    parameter int MEM_AW    = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_LEN-1:0]  address,
    input  logic [DATA_LEN-1:0]  data,
    input  logic                 data_valid,
    input  logic [BURST_LEN-1:0] burst_num,
    input  logic [SLAVE_LEN-1:0] slave_select,
    input  logic [1:0]           instruction,
    output logic [DATA_LEN-1:0]  rd_data,
    output logic                 rd_valid,
    output logic                 tx_done,
    output logic                 rx_done,
    output logic                 busy,
    output logic                 err
);

    localparam int unsigned DEPTH = 1 << MEM_AW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DONE,
        S_RELEASE
    } state_t;

    state_t               r_state;
    logic [MEM_AW-1:0]    r_ptr;
    logic [BURST_LEN-1:0] r_cnt;
    logic                 r_rdPend;
    logic [DATA_LEN-1:0]  r_mem [0:DEPTH-1];
    logic [DATA_LEN-1:0]  r_memQ;
    logic [DATA_LEN-1:0]  r_rdData;
    logic                 r_rdValid;
    logic                 r_txDone;
    logic                 r_rxDone;
    logic                 r_busy;

    logic                 w_accept;
    logic [BURST_LEN-1:0] w_burst;
    logic                 w_rangeErr;
    logic                 w_memWe;

    assign w_accept = (r_state == S_IDLE) && instruction[1]
                      && (slave_select == SLAVE_LEN'(SLAVE_ID));
    assign w_burst  = (burst_num == '0) ? BURST_LEN'(1) : burst_num;
    assign w_memWe  = (r_state == S_WRITE) && data_valid && !reset;

`ifdef SLAVE_ERR_EN
    logic [31:0] w_end;
    logic        r_err;

    assign w_end      = 32'(address[MEM_AW-1:0]) + 32'(w_burst);
    assign w_rangeErr = ((address >> MEM_AW) != '0) || (w_end > 32'(DEPTH));
    assign err        = r_err;
`else
    logic w_unusedAddrHi;

    // Upper address bits alias onto the RAM when no range check is built in.
    assign w_unusedAddrHi = &{1'b0, address[ADDR_LEN-1:MEM_AW]};
    assign w_rangeErr     = 1'b0;
    assign err            = 1'b0;
`endif

    assign rd_data  = r_rdData;
    assign rd_valid = r_rdValid;
    assign tx_done  = r_txDone;
    assign rx_done  = r_rxDone;
    assign busy     = r_busy;

    // Synchronous-read RAM; the registered read adds one cycle before the first read beat.
    always_ff @(posedge clk) begin
        if (w_memWe) begin
            r_mem[r_ptr] <= data;
        end
        r_memQ <= r_mem[r_ptr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_rdPend  <= 1'b0;
            r_rdData  <= '0;
            r_rdValid <= 1'b0;
            r_txDone  <= 1'b0;
            r_rxDone  <= 1'b0;
            r_busy    <= 1'b0;
`ifdef SLAVE_ERR_EN
            r_err     <= 1'b0;
`endif
        end else begin
            r_txDone <= 1'b0;
            r_rxDone <= 1'b0;
`ifdef SLAVE_ERR_EN
            r_err    <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_ptr    <= address[MEM_AW-1:0];
                        r_cnt    <= w_burst;
                        r_rdPend <= 1'b0;
                        r_busy   <= 1'b1;
                        if (w_rangeErr) begin
                            r_state  <= S_DONE;
                            r_txDone <= ~instruction[0];
                            r_rxDone <= instruction[0];
`ifdef SLAVE_ERR_EN
                            r_err    <= 1'b1;
`endif
                        end else begin
                            r_state <= instruction[0] ? S_READ : S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (data_valid) begin
                        r_ptr <= r_ptr + 1'b1;
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == BURST_LEN'(1)) begin
                            r_state  <= S_DONE;
                            r_txDone <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    // cnt reaches zero on the last emitted beat; the following edge retires the burst.
                    if (r_cnt == '0) begin
                        r_rdValid <= 1'b0;
                        r_rxDone  <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_ptr    <= r_ptr + 1'b1;
                        r_rdPend <= 1'b1;
                        if (r_rdPend) begin
                            r_rdData  <= r_memQ;
                            r_rdValid <= 1'b1;
                            r_cnt     <= r_cnt - 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (!instruction[1]) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_slave_responder.sv
// Self-checking bench for bus_slave_responder: transaction-level model of RAM and output timeline,
// compared every cycle on the falling edge; honours SLAVE_ERR_EN when the build defines it.
module tb_bus_slave_responder;

    localparam int SLAVE_ID = 0;
    localparam int MEM_AW   = 10;
    localparam int DEPTH    = 1 << MEM_AW;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] address;
    logic [7:0]  data;
    logic        dataValid;
    logic [11:0] burstNum;
    logic [1:0]  slaveSelect;
    logic [1:0]  instruction;
    logic [7:0]  rdData;
    logic        rdValid;
    logic        txDone;
    logic        rxDone;
    logic        busy;
    logic        err;

    logic [7:0]  modelMem [0:DEPTH-1];
    logic [7:0]  wrData [$];
    logic [7:0]  readCapture [$];

    logic [7:0]  expRdData;
    logic        expRdValid, expTx, expRx, expBusy, expErr;
    bit          checkEn = 1'b0;
    int          nChecks = 0;
    int          nFails  = 0;

    bus_slave_responder #(
        .SLAVE_LEN(2), .ADDR_LEN(12), .DATA_LEN(8), .BURST_LEN(12),
        .SLAVE_ID(SLAVE_ID), .MEM_AW(MEM_AW)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .data(data),
        .data_valid(dataValid), .burst_num(burstNum), .slave_select(slaveSelect),
        .instruction(instruction), .rd_data(rdData), .rd_valid(rdValid),
        .tx_done(txDone), .rx_done(rxDone), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("rd_valid", 32'(rdValid), 32'(expRdValid));
            checkOutput("rd_data", 32'(rdData), 32'(expRdData));
            checkOutput("tx_done", 32'(txDone), 32'(expTx));
            checkOutput("rx_done", 32'(rxDone), 32'(expRx));
            checkOutput("busy", 32'(busy), 32'(expBusy));
            checkOutput("err", 32'(err), 32'(expErr));
        end
    end

    // Advance one clock and publish what the outputs must show after that edge.
    task automatic step(input bit v, input logic [7:0] d, input bit tx, input bit rx, input bit b, input bit e);
        @(posedge clk);
        #1;
        expRdValid = v;
        if (v) expRdData = d;
        expTx   = tx;
        expRx   = rx;
        expBusy = b;
        expErr  = e;
    endtask

    task automatic scramble(input logic [1:0] instr);
        address     = 12'($urandom);
        burstNum    = 12'($urandom);
        slaveSelect = 2'($urandom);
        instruction = {instr[1], 1'($urandom)};
        data        = 8'($urandom);
        dataValid   = 1'($urandom);
    endtask

    task automatic applyStimulus(input logic [1:0] instr, input logic [1:0] sel, input logic [11:0] addr,
                                 input logic [11:0] burst, input int hold, input int stallPct);
        int  n    = (burst == 0) ? 1 : int'(burst);
        int  base = int'(addr) % DEPTH;
        bit  op   = instr[0];
        bit  isErr = 1'b0;
`ifdef SLAVE_ERR_EN
        isErr = ((int'(addr) >> MEM_AW) != 0) || (base + n > DEPTH);
`endif
        address = addr; burstNum = burst; slaveSelect = sel; instruction = instr;
        data = 8'($urandom); dataValid = 1'($urandom);
        if (!(instr[1] && sel == 2'(SLAVE_ID))) begin
            step(0, 0, 0, 0, 0, 0);
            instruction = 2'b00;
            return;
        end
        if (isErr) begin
            step(0, 0, ~op, op, 1, 1);
            wrData.delete();
        end else begin
            step(0, 0, 0, 0, 1, 0);
            if (!op) begin
                for (int i = 0; i < n; ) begin
                    scramble(instr);
                    dataValid = ($urandom_range(0, 99) >= stallPct);
                    if (dataValid) begin
                        data = (wrData.size() != 0) ? wrData.pop_front() : 8'($urandom);
                        modelMem[(base + i) % DEPTH] = data;
                        i++;
                    end
                    step(0, 0, (i == n) && dataValid, 0, 1, 0);
                end
            end else begin
                scramble(instr);
                step(0, 0, 0, 0, 1, 0);
                for (int i = 0; i < n; i++) begin
                    scramble(instr);
                    step(1, modelMem[(base + i) % DEPTH], 0, 0, 1, 0);
                    readCapture.push_back(rdData);
                end
                scramble(instr);
                step(0, 0, 0, 1, 1, 0);
            end
        end
        scramble(instr);
        step(0, 0, 0, 0, 1, 0);
        for (int h = 0; h < hold; h++) begin
            scramble(instr);
            step(0, 0, 0, 0, 1, 0);
        end
        instruction = 2'b00;
        step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [7:0] lit3 [3];
        logic [7:0] lit2 [2];
        lit3 = '{8'hA1, 8'hB2, 8'hC3};
        lit2 = '{8'h5A, 8'h6B};
        reset = 1'b1; address = '0; data = '0; dataValid = 1'b0;
        burstNum = '0; slaveSelect = '0; instruction = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        expRdValid = 0; expRdData = 0; expTx = 0; expRx = 0; expBusy = 0; expErr = 0;
        checkEn = 1'b1;
        reset = 1'b0;
        step(0, 0, 0, 0, 0, 0);

        applyStimulus(2'b10, 2'd0, 12'h000, 12'd1024, 0, 0);

        wrData = '{8'hA1, 8'hB2, 8'hC3};
        applyStimulus(2'b10, 2'd0, 12'h005, 12'd3, 0, 0);
        readCapture.delete();
        applyStimulus(2'b11, 2'd0, 12'h005, 12'd3, 0, 0);
        checkOutput("t2_beats", 32'(readCapture.size()), 32'd3);
        for (int i = 0; i < 3 && i < readCapture.size(); i++)
            checkOutput("t2_literal", 32'(readCapture[i]), 32'(lit3[i]));

        applyStimulus(2'b10, 2'd1, 12'h005, 12'd3, 0, 0);
        applyStimulus(2'b01, 2'd0, 12'h005, 12'd3, 0, 0);
        applyStimulus(2'b11, 2'd2, 12'h005, 12'd3, 0, 0);
        readCapture.delete();
        applyStimulus(2'b11, 2'd0, 12'h005, 12'd3, 0, 0);
        for (int i = 0; i < 3 && i < readCapture.size(); i++)
            checkOutput("t3_ram_kept", 32'(readCapture[i]), 32'(lit3[i]));

        applyStimulus(2'b10, 2'd0, 12'h100, 12'd2, 5, 20);
        applyStimulus(2'b11, 2'd0, 12'h100, 12'd0, 2, 0);

        wrData = '{8'h5A, 8'h6B};
        applyStimulus(2'b10, 2'd0, 12'h3FF, 12'd2, 0, 0);
`ifndef SLAVE_ERR_EN
        readCapture.delete();
        applyStimulus(2'b11, 2'd0, 12'h3FF, 12'd2, 0, 0);
        checkOutput("t5_beats", 32'(readCapture.size()), 32'd2);
        for (int i = 0; i < 2 && i < readCapture.size(); i++)
            checkOutput("t5_wrap", 32'(readCapture[i]), 32'(lit2[i]));
`else
        applyStimulus(2'b11, 2'd0, 12'h3FF, 12'd1, 0, 0);
        applyStimulus(2'b11, 2'd0, 12'h000, 12'd1, 0, 0);
`endif

        for (int t = 0; t < 40; t++) begin
            applyStimulus({($urandom_range(0, 9) != 0), 1'($urandom)},
                          ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'(SLAVE_ID),
                          ($urandom_range(0, 1) != 0) ? 12'($urandom) : 12'($urandom_range(0, 1000)),
                          12'($urandom_range(0, 20)), $urandom_range(0, 3), 30);
        end

        address = 12'h005; burstNum = 12'd4; slaveSelect = 2'(SLAVE_ID); instruction = 2'b11;
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(1, modelMem[5], 0, 0, 1, 0);
        step(1, modelMem[6], 0, 0, 1, 0);
        reset = 1'b1;
        instruction = 2'b00;
        @(posedge clk);
        #1;
        expRdValid = 0; expRdData = 0; expTx = 0; expRx = 0; expBusy = 0; expErr = 0;
        reset = 1'b0;
        repeat (4) step(0, 0, 0, 0, 0, 0);
        applyStimulus(2'b11, 2'd0, 12'h006, 12'd2, 0, 0);

        @(posedge clk);
        checkEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
